// File: rtl/clock_pkg.sv
// Shared encodings for the clock mode controller: modes, edit positions and blink-mask slots.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_CLOCK = 2'd0,
    MODE_SETUP = 2'd1,
    MODE_ALARM = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    POS_SEC  = 2'd0,
    POS_MIN  = 2'd1,
    POS_HOUR = 2'd2
  } pos_e;

  localparam int MASK_SEC_LSB  = 0;
  localparam int MASK_MIN_LSB  = 2;
  localparam int MASK_HOUR_LSB = 4;

  // Both digits of the selected field follow the blink phase; everything else stays lit.
  function automatic logic [5:0] pos_mask(input pos_e pos, input logic phase);
    logic [5:0] m;
    m = '0;
    case (pos)
      POS_SEC:  m[MASK_SEC_LSB  +: 2] = {2{phase}};
      POS_MIN:  m[MASK_MIN_LSB  +: 2] = {2{phase}};
      POS_HOUR: m[MASK_HOUR_LSB +: 2] = {2{phase}};
      default:  m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Divider: o_tick is high in the last cycle of each DIV-cycle period.
// i_clr synchronously returns the count to 0 and suppresses the tick.
module tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = (r_cnt == LAST) && !i_clr;

endmodule

// File: rtl/clock_mode_ctrl.sv
// Button-driven mode/position controller and enable-strobe scheduler for the digital clock.
// Presses act 3 cycles after the button falls; every strobe is registered and one cycle wide.
module clock_mode_ctrl
  import clock_pkg::*;
#(
  parameter int TICK_DIV  = 50000000,
  parameter int BLINK_DIV = 12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sw_mode,
  input  logic       i_sw_pos,
  input  logic       i_sw_inc,
  input  logic       i_sec_max,
  input  logic       i_min_max,
  output logic [1:0] o_mode,
  output logic [1:0] o_position,
  output logic       o_sec_en,
  output logic       o_min_en,
  output logic       o_hour_en,
  output logic       o_alm_min_en,
  output logic       o_alm_hour_en,
  output logic       o_alarm_en,
  output logic [5:0] o_blink_mask
);

  // Bit order everywhere: [0] mode, [1] pos, [2] inc.
  logic [2:0] r_sync1, r_sync2, r_sync3;
  logic [2:0] w_press;
  logic       w_ev_mode, w_ev_pos, w_ev_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_sync3 <= '1;
    end else begin
      r_sync1 <= {i_sw_inc, i_sw_pos, i_sw_mode};
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_press   = r_sync3 & ~r_sync2;
  assign w_ev_mode = w_press[0];
  assign w_ev_pos  = w_press[1] & ~w_press[0];
  assign w_ev_inc  = w_press[2] & ~w_press[1] & ~w_press[0];

  mode_e      r_mode, w_mode_nxt;
  pos_e       r_pos, w_pos_nxt;
  logic       r_alarm_en, w_alarm_nxt;
  logic [4:0] r_stb, w_stb_nxt;  // {alm_hour, alm_min, hour, min, sec}
  logic [1:0] w_mode_raw, w_pos_raw;
  logic       w_illegal, w_tick, w_change, w_blink_clr, w_blink_tick;
  logic       r_phase;

  assign w_mode_raw = r_mode;
  assign w_pos_raw  = r_pos;
  assign w_illegal  = (w_mode_raw == 2'd3) || (w_pos_raw == 2'd3);

  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (r_mode == MODE_SETUP),
    .o_tick (w_tick)
  );

  assign w_change    = (w_mode_nxt != r_mode) || (w_pos_nxt != r_pos);
  assign w_blink_clr = (r_mode == MODE_CLOCK) || w_change;

  tick_gen #(.DIV(BLINK_DIV)) u_blink (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_blink_clr),
    .o_tick (w_blink_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode     <= MODE_CLOCK;
      r_pos      <= POS_SEC;
      r_alarm_en <= 1'b0;
      r_stb      <= '0;
      r_phase    <= 1'b0;
    end else begin
      r_mode     <= w_mode_nxt;
      r_pos      <= w_pos_nxt;
      r_alarm_en <= w_alarm_nxt;
      r_stb      <= w_stb_nxt;
      r_phase    <= w_blink_clr ? 1'b0 : (r_phase ^ w_blink_tick);
    end
  end

  always_comb begin
    w_mode_nxt  = r_mode;
    w_pos_nxt   = r_pos;
    w_alarm_nxt = r_alarm_en;
    w_stb_nxt   = '0;
    if (w_illegal) begin
      w_mode_nxt = MODE_CLOCK;
      w_pos_nxt  = POS_SEC;
    end else begin
      // Tick is held off in SETUP, so it never collides with a SETUP increment.
      if (w_tick) begin
        w_stb_nxt[0] = 1'b1;
        w_stb_nxt[1] = i_sec_max;
        w_stb_nxt[2] = i_sec_max & i_min_max;
      end
      case (r_mode)
        MODE_CLOCK: begin
          if (w_ev_mode) begin
            w_mode_nxt = MODE_SETUP;
            w_pos_nxt  = POS_SEC;
          end else if (w_ev_inc) begin
            w_alarm_nxt = ~r_alarm_en;
          end
        end
        MODE_SETUP: begin
          if (w_ev_mode) begin
            w_mode_nxt = MODE_ALARM;
            w_pos_nxt  = POS_MIN;
          end else if (w_ev_pos) begin
            case (r_pos)
              POS_SEC: w_pos_nxt = POS_MIN;
              POS_MIN: w_pos_nxt = POS_HOUR;
              default: w_pos_nxt = POS_SEC;
            endcase
          end else if (w_ev_inc) begin
            case (r_pos)
              POS_SEC:  w_stb_nxt[0] = 1'b1;
              POS_MIN:  w_stb_nxt[1] = 1'b1;
              POS_HOUR: w_stb_nxt[2] = 1'b1;
              default:  w_stb_nxt[0] = 1'b0;
            endcase
          end
        end
        MODE_ALARM: begin
          if (w_ev_mode) begin
            w_mode_nxt = MODE_CLOCK;
            w_pos_nxt  = POS_SEC;
          end else if (w_ev_pos) begin
            w_pos_nxt = (r_pos == POS_MIN) ? POS_HOUR : POS_MIN;
          end else if (w_ev_inc) begin
            if (r_pos == POS_MIN)  w_stb_nxt[3] = 1'b1;
            if (r_pos == POS_HOUR) w_stb_nxt[4] = 1'b1;
          end
        end
        default: begin
          w_mode_nxt = MODE_CLOCK;
          w_pos_nxt  = POS_SEC;
        end
      endcase
    end
  end

  assign o_mode        = r_mode;
  assign o_position    = r_pos;
  assign o_alarm_en    = r_alarm_en;
  assign o_sec_en      = r_stb[0];
  assign o_min_en      = r_stb[1];
  assign o_hour_en     = r_stb[2];
  assign o_alm_min_en  = r_stb[3];
  assign o_alm_hour_en = r_stb[4];
  assign o_blink_mask  = (r_mode == MODE_SETUP || r_mode == MODE_ALARM) ?
                         pos_mask(r_pos, r_phase) : 6'b0;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Randomised bench for clock_mode_ctrl: a cycle-level reference model queues the expected
// outputs after every clock edge and a negedge monitor compares them against the DUT.
module tb_clock_mode_ctrl;

  localparam int TICK_DIV  = 10;
  localparam int BLINK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] sw = 3'b111;  // [0] mode, [1] pos, [2] inc
  logic       sec_max = 1'b0;
  logic       min_max = 1'b0;
  logic [1:0] o_mode, o_position;
  logic       o_sec_en, o_min_en, o_hour_en, o_alm_min_en, o_alm_hour_en, o_alarm_en;
  logic [5:0] o_blink_mask;

  always #5 clk = ~clk;

  clock_mode_ctrl #(.TICK_DIV(TICK_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_sw_mode     (sw[0]),
    .i_sw_pos      (sw[1]),
    .i_sw_inc      (sw[2]),
    .i_sec_max     (sec_max),
    .i_min_max     (min_max),
    .o_mode        (o_mode),
    .o_position    (o_position),
    .o_sec_en      (o_sec_en),
    .o_min_en      (o_min_en),
    .o_hour_en     (o_hour_en),
    .o_alm_min_en  (o_alm_min_en),
    .o_alm_hour_en (o_alm_hour_en),
    .o_alarm_en    (o_alarm_en),
    .o_blink_mask  (o_blink_mask)
  );

  typedef struct packed {
    logic [1:0] mode;
    logic [1:0] pos;
    logic [4:0] stb;  // {sec, min, hour, alm_min, alm_hour}
    logic       alarm;
    logic [5:0] mask;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference model: modes 0=CLOCK 1=SETUP 2=ALARM, positions 0=SEC 1=MIN 2=HOUR.
  int       m_mode, m_pos, m_trun, m_brun;
  bit       m_alarm, m_phase;
  bit [4:0] m_stb;
  bit [2:0] h1, h2, h3;  // button samples taken 1, 2 and 3 edges ago

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_trun = 0; m_brun = 0;
    m_alarm = 1'b0; m_phase = 1'b0; m_stb = '0;
    h1 = '1; h2 = '1; h3 = '1;
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.mode  = 2'(m_mode);
    o.pos   = 2'(m_pos);
    o.stb   = m_stb;
    o.alarm = m_alarm;
    o.mask  = (m_mode != 0 && m_phase) ? 6'(6'b000011 << (2 * m_pos)) : 6'b0;
    return o;
  endfunction

  task automatic model_step();
    bit [2:0] pr;
    bit       tick, chg;
    int       nm, np;
    pr = h3 & ~h2;  // a release-to-press transition seen two samples ago acts now
    h3 = h2; h2 = h1; h1 = sw;
    nm = m_mode; np = m_pos;
    m_stb = '0;
    tick = 1'b0;
    if (m_mode == 1) m_trun = 0;
    else begin
      m_trun++;
      tick = (m_trun % TICK_DIV) == 0;
    end
    if (tick) m_stb = {1'b1, sec_max, sec_max & min_max, 2'b00};
    if (pr[0]) begin
      nm = (m_mode + 1) % 3;
      np = (nm == 2) ? 1 : 0;
    end else if (pr[1]) begin
      if (m_mode == 1) np = (m_pos + 1) % 3;
      else if (m_mode == 2) np = 3 - m_pos;
    end else if (pr[2]) begin
      if (m_mode == 0) m_alarm = !m_alarm;
      else if (m_mode == 1) m_stb = 5'(5'b10000 >> m_pos);
      else m_stb[1 - (m_pos - 1)] = 1'b1;
    end
    chg = (nm != m_mode) || (np != m_pos);
    if (m_mode == 0 || chg) begin
      m_brun = 0; m_phase = 1'b0;
    end else begin
      m_brun++;
      if (m_brun % BLINK_DIV == 0) m_phase = !m_phase;
    end
    m_mode = nm; m_pos = np;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    exp_q.push_back(model_obs());
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic press(input bit [2:0] which, input int hold, input int gap);
    sw = sw & ~which;
    idle(hold);
    sw = sw | which;
    idle(gap);
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    model_reset();
    if (exp_q.size() > 0) exp_q[exp_q.size() - 1] = model_obs();
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t e, a;
      e = exp_q.pop_front();
      a.mode = o_mode; a.pos = o_position; a.alarm = o_alarm_en; a.mask = o_blink_mask;
      a.stb = {o_sec_en, o_min_en, o_hour_en, o_alm_min_en, o_alm_hour_en};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs t=%0t got mode=%0d pos=%0d stb=%b alarm=%b mask=%b required mode=%0d pos=%0d stb=%b alarm=%b mask=%b",
                 $time, a.mode, a.pos, a.stb, a.alarm, a.mask, e.mode, e.pos, e.stb, e.alarm, e.mask);
      end
    end
  end

  initial begin
    model_reset();
    idle(3);
    rst_n = 1'b1;
    idle(35);                                   // plain timekeeping
    sec_max = 1'b1; min_max = 1'b1; idle(12);   // full carry
    sec_max = 1'b1; min_max = 1'b0; idle(10);
    sec_max = 1'b0;
    press(3'b001, $urandom_range(1, 5), 6);     // -> SETUP
    press(3'b100, 2, 50);                       // single seconds increment, no ticks
    press(3'b010, 1, 4);  press(3'b100, 3, 6);  // MIN, increment minutes
    press(3'b010, 2, 20);                       // HOUR, watch blink
    press(3'b100, 1, 5);
    press(3'b010, 2, 10);                       // back to SEC
    press(3'b001, 2, 6);                        // -> ALARM at MIN
    press(3'b100, 2, 6);
    press(3'b010, 1, 6);  press(3'b100, 1, 25); // HOUR, timekeeping continues
    press(3'b001, 2, 6);                        // -> CLOCK
    press(3'b100, 2, 8);                        // arm alarm
    press(3'b101, 2, 8);                        // mode wins over inc
    press(3'b011, 2, 8);                        // mode wins over pos
    sw[1] = 1'b0; idle(2);                      // reset while a button is held
    assert_reset(); idle(3);
    rst_n = 1'b1; idle(2);
    sw[1] = 1'b1; idle(10);
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 19) == 0) sw[b] = ~sw[b];
      sec_max = ($urandom_range(0, 2) == 0);
      min_max = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 499) == 0) begin
        assert_reset(); idle(2); rst_n = 1'b1;
      end
      cycle();
    end
    sw = 3'b111;
    idle(5);
    repeat (3) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries never compared, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
